food_pos_gen: RTL

- Parametrised successor to the snake-food position generator.
- Free-running Galois LFSR supplies candidate (x,y) coordinates inside a GRID_W x GRID_H playfield.
- Rejection-samples out-of-range candidates and candidates occupied by the snake, using a one-cycle occupancy lookup into the body map.
- Sits between game control (request/valid) and the snake-body occupancy memory.

---
 rtl/food_pos_gen_pkg.sv | 29 ++
 rtl/food_pos_gen_lfsr.sv | 33 +++
 rtl/food_pos_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/food_pos_gen_pkg.sv
// Shared definitions for the snake-food position generator.
//   state_t      : FSM encoding (explicit values keep the legacy 3-bit codes)
//   lfsr_taps()  : Galois right-shift tap masks for 8/16/24/32-bit LFSRs
//   DEFAULT_SEED : default LFSR reset value
package food_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_QUERY = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Maximal-length tap masks for a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      16:      lfsr_taps = 32'h0000_B400;
      24:      lfsr_taps = 32'h00E1_0000;
      32:      lfsr_taps = 32'hA300_0000;
      default: lfsr_taps = 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/food_pos_gen_lfsr.sv
// Free-running Galois LFSR (right shift) with synchronous reseed.
//   clk, rst  : clock, synchronous active-high reset (q <= SEED)
//   load      : load load_val this edge (a zero load_val loads SEED instead)
//   load_val  : reseed value
//   q         : current LFSR state
// An all-zero state can never advance, so it is replaced by SEED on the next edge.
module lfsr_galois
  import food_gen_pkg::*;
#(
  parameter int unsigned    W    = 16,
  parameter logic [W-1:0]   TAPS = 16'hB400,
  parameter logic [W-1:0]   SEED = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val == '0) ? SEED : load_val;
    end else if (q == '0) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/food_pos_gen.sv
// Snake-food position generator.
// Draws (x,y) candidates from a free-running LFSR, rejects those outside the
// GRID_W x GRID_H playfield or occupied by the snake body (one-cycle lookup via
// occ_rd/occ_x/occ_y -> occ_hit), and reports a free cell or failure after
// MAX_TRIES draws.
//   clk, rst          : clock, synchronous active-high reset
//   req               : request a new position (sampled only when idle)
//   busy              : FSM not idle
//   pos_valid         : one-cycle pulse, pos_x/pos_y hold a new free cell
//   pos_fail          : one-cycle pulse, MAX_TRIES draws exhausted
//   pos_x, pos_y      : last accepted position, held between pulses
//   occ_rd            : occupancy lookup strobe (one cycle per in-range draw)
//   occ_x, occ_y      : lookup coordinates, held between strobes
//   occ_hit           : occupancy result, sampled in the cycle after occ_rd
// Optional build macro FOOD_SEED_LOAD_EN adds seed_load / seed_in to reseed
// the LFSR at runtime (rst takes priority; FSM unaffected).
module food_pos_gen
  import food_gen_pkg::*;
#(
  parameter int unsigned             X_W       = 5,
  parameter int unsigned             Y_W       = 5,
  parameter int unsigned             GRID_W    = 30,
  parameter int unsigned             GRID_H    = 20,
  parameter int unsigned             LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]       SEED      = DEFAULT_SEED,
  parameter int unsigned             MAX_TRIES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              busy,
  output logic              pos_valid,
  output logic              pos_fail,
  output logic [X_W-1:0]    pos_x,
  output logic [Y_W-1:0]    pos_y,
  output logic              occ_rd,
  output logic [X_W-1:0]    occ_x,
  output logic [Y_W-1:0]    occ_y,
  input  logic              occ_hit
`ifdef FOOD_SEED_LOAD_EN
  ,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in
`endif
);

  localparam logic [31:0]       TAPS_FULL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];
  // One extra bit so GRID_W = 2**X_W is representable and never rejects.
  localparam logic [X_W:0]      GW        = GRID_W[X_W:0];
  localparam logic [Y_W:0]      GH        = GRID_H[Y_W:0];
  localparam logic [7:0]        MT        = MAX_TRIES[7:0];

  state_t            state;
  logic [7:0]        tries;
  logic [7:0]        tries_inc;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_load_val;
  logic [X_W-1:0]    cx;
  logic [Y_W-1:0]    cy;
  logic              in_range;

`ifdef FOOD_SEED_LOAD_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = seed_in;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr)
  );

  assign cx        = lfsr[X_W-1:0];
  assign cy        = lfsr[X_W+Y_W-1:X_W];
  assign in_range  = ({1'b0, cx} < GW) && ({1'b0, cy} < GH);
  assign tries_inc = tries + 8'd1;

  if (X_W + Y_W < LFSR_W) begin : g_spare
    logic unused_hi;
    assign unused_hi = ^lfsr[LFSR_W-1:X_W+Y_W];
  end

  // Strobes are state decodes, so they are low out of reset and last exactly
  // one cycle because QUERY/DONE/FAIL are single-cycle states.
  assign busy      = (state != ST_IDLE);
  assign occ_rd    = (state == ST_QUERY);
  assign pos_valid = (state == ST_DONE);
  assign pos_fail  = (state == ST_FAIL);

  // occ_x/occ_y double as the candidate register: only in-range draws load
  // them, so they stay stable between lookups.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tries <= '0;
      occ_x <= '0;
      occ_y <= '0;
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            tries <= '0;
            state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          tries <= tries_inc;
          if (!in_range) begin
            state <= (tries_inc == MT) ? ST_FAIL : ST_DRAW;
          end else begin
            occ_x <= cx;
            occ_y <= cy;
            state <= ST_QUERY;
          end
        end
        ST_QUERY: state <= ST_WAIT;
        ST_WAIT: begin
          if (occ_hit) begin
            state <= (tries == MT) ? ST_FAIL : ST_DRAW;
          end else begin
            pos_x <= occ_x;
            pos_y <= occ_y;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_FAIL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
